// File: rtl/lsu.sv
// Load/store unit: one RV32I memory op at a time, B/H/W lane steering and load extension.
// Latency: request on the bus the cycle after capture; o_done one cycle after store handshake or load response.
// Backpressure: o_ready only in IDLE; the bus request holds stable until i_dmem_ready.
module lsu (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic        i_load,
  input  logic        i_store,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_dmem_valid,
  output logic [31:0] o_dmem_addr,
  output logic        o_dmem_wen,
  output logic [3:0]  o_dmem_mask,
  output logic [31:0] o_dmem_wdata,
  input  logic        i_dmem_ready,
  input  logic        i_dmem_rvalid,
  input  logic [31:0] i_dmem_rdata,
  output logic        o_done,
  output logic [31:0] o_rdata,
  output logic        o_misaligned
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state;
  logic        r_sz_b;
  logic        r_sz_h;
  logic        r_unsigned;
  logic [1:0]  r_off;

  logic        is_load;
  logic        is_store;
  logic        sz_b;
  logic        sz_h;
  logic        misaligned;
  logic [3:0]  mask;
  logic [31:0] wdata_lane;
  logic [31:0] shifted;
  logic [31:0] load_val;

  assign o_ready = (state == IDLE);

  // Request decode; undefined width codes fall through to word.
  always_comb begin
    is_load    = i_load;
    is_store   = i_store & ~i_load;
    sz_b       = (i_funct3 == 3'b000) || (i_funct3 == 3'b100);
    sz_h       = (i_funct3 == 3'b001) || (i_funct3 == 3'b101);
    misaligned = (sz_h && i_addr[0]) || (!sz_b && !sz_h && (i_addr[1:0] != 2'b00));
    if (sz_b) begin
      mask       = 4'b0001 << i_addr[1:0];
      wdata_lane = {4{i_wdata[7:0]}};
    end else if (sz_h) begin
      mask       = 4'b0011 << i_addr[1:0];
      wdata_lane = {2{i_wdata[15:0]}};
    end else begin
      mask       = 4'b1111;
      wdata_lane = i_wdata;
    end
  end

  always_comb begin
    shifted = i_dmem_rdata >> {r_off, 3'b000};
    if (r_sz_b) begin
      load_val = {{24{shifted[7] & ~r_unsigned}}, shifted[7:0]};
    end else if (r_sz_h) begin
      load_val = {{16{shifted[15] & ~r_unsigned}}, shifted[15:0]};
    end else begin
      load_val = i_dmem_rdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= IDLE;
      o_dmem_valid <= 1'b0;
      o_dmem_addr  <= '0;
      o_dmem_wen   <= 1'b0;
      o_dmem_mask  <= '0;
      o_dmem_wdata <= '0;
      o_done       <= 1'b0;
      o_rdata      <= '0;
      o_misaligned <= 1'b0;
      r_sz_b       <= 1'b0;
      r_sz_h       <= 1'b0;
      r_unsigned   <= 1'b0;
      r_off        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            r_sz_b     <= sz_b;
            r_sz_h     <= sz_h;
            r_unsigned <= i_funct3[2];
            r_off      <= i_addr[1:0];
            if ((is_load || is_store) && !misaligned) begin
              state        <= REQ;
              o_dmem_valid <= 1'b1;
              o_dmem_addr  <= {i_addr[31:2], 2'b00};
              o_dmem_wen   <= is_store;
              o_dmem_mask  <= mask;
              o_dmem_wdata <= wdata_lane;
            end else begin
              // Misaligned or no-op: complete without touching the bus.
              state        <= DONE;
              o_done       <= 1'b1;
              o_misaligned <= (is_load || is_store);
              if (is_load) o_rdata <= '0;
            end
          end
        end
        REQ: begin
          if (i_dmem_ready) begin
            o_dmem_valid <= 1'b0;
            if (o_dmem_wen) begin
              state  <= DONE;
              o_done <= 1'b1;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (i_dmem_rvalid) begin
            state   <= DONE;
            o_done  <= 1'b1;
            o_rdata <= load_val;
          end
        end
        default: begin
          state        <= IDLE;
          o_done       <= 1'b0;
          o_misaligned <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high: ports i_clk (input, 1, rising-edge clock) and i_rst (input, 1, synchronous active-high reset).
REQ-002 i_valid  input  1  execute stage presents a memory operation.
REQ-003 o_ready  output 1  LSU idle and able to accept; a request is captured at a rising edge where i_valid && o_ready.
REQ-004 i_load, i_store  input  1 each  operation type; both high SHALL be treated as load; neither high SHALL be a no-op.
REQ-005 i_funct3  input  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU; other codes SHALL be treated as W.
REQ-006 i_addr  input  32  byte address, taken from the ALU result.
REQ-007 i_wdata  input  32  store data (rs2), right-justified.
REQ-008 o_dmem_valid  output 1  bus request valid; o_dmem_addr output 32 (word-aligned, bits[1:0]=00); o_dmem_wen output 1 (1 = write); o_dmem_mask output 4 (byte enables); o_dmem_wdata output 32 (lane-shifted).
REQ-009 i_dmem_ready  input  1  bus accepts the request at an edge where o_dmem_valid && i_dmem_ready.
REQ-010 i_dmem_rvalid  input 1, i_dmem_rdata  input 32  load response word.
REQ-011 o_done  output 1  one-cycle completion pulse; o_rdata output 32 (aligned, extended load result); o_misaligned output 1 (valid with o_done).

Function
REQ-012 FSM states: IDLE, REQ, WAIT, DONE; o_ready SHALL equal (state==IDLE).
REQ-013 IDLE + capture: aligned load/store -> REQ; misaligned or no-op -> DONE; all request fields registered at capture.
REQ-014 Misaligned: H/HU with addr[0]=1, or W with addr[1:0]!=00; no bus request SHALL be issued.
REQ-015 REQ: o_dmem_valid=1 with addr/wen/mask/wdata held stable until handshake; on handshake, store -> DONE, load -> WAIT.
REQ-016 WAIT: on i_dmem_rvalid -> DONE, registering the extracted load data; i_dmem_rvalid outside WAIT SHALL be ignored.
REQ-017 DONE: o_done=1 for exactly one cycle, then -> IDLE; o_misaligned=1 in DONE only for misaligned requests.
REQ-018 Latency: capture at edge N -> o_dmem_valid from cycle N+1; store handshake at edge M -> o_done in cycle M+1; rvalid at edge K -> o_done in cycle K+1; misaligned/no-op -> o_done in cycle N+1.
REQ-019 Mask: B = 1 << addr[1:0]; H = 4'b0011 << addr[1:0]; W = 4'b1111; loads use the same mask.
REQ-020 Store data: B replicated to all 4 lanes; H replicated to both halves; W unchanged.
REQ-021 Load extract: select byte/half by addr[1:0]; B/H sign-extend from the top bit of the selected item; BU/HU zero-extend.
REQ-022 o_rdata SHALL update only on a load completion (misaligned load -> 0) and hold otherwise.

Reset
REQ-023 On i_rst at any state, the next state SHALL be IDLE, with o_dmem_valid=0, o_done=0, o_misaligned=0, o_rdata=0, o_dmem_addr/mask/wdata=0, and o_dmem_wen=0.
REQ-024 Reset mid-transaction SHALL abandon the operation; a later i_dmem_rvalid SHALL produce no o_done.

Verification
REQ-025 SB addr 0x00001003, wdata 0x000000AB -> o_dmem_addr 0x00001000, mask 4'b1000, wdata 0xABABABAB, wen=1; o_done one cycle after handshake.
REQ-026 LH addr 0x00002002, rdata 0x80011234 -> o_rdata 0xFFFF8001; LHU same -> 0x00008001; LB addr 0x2000 -> 0x00000034.
REQ-027 LW addr 0x00003002 -> no o_dmem_valid; o_done and o_misaligned high in cycle N+1; o_rdata 0.
REQ-028 i_dmem_ready held low 3 cycles in REQ -> o_dmem_valid stays high, all bus fields stable, o_ready=0, i_valid ignored.
REQ-029 i_rst during WAIT, then i_dmem_rvalid=1 -> o_ready=1 after reset, no o_done pulse, o_rdata=0.
REQ-030 Back-to-back SW then LW to 0x4000 -> second request accepted in the cycle after the first o_done; bus order preserved.
